// File: rtl/key_input_pkg.sv
// Shared constants for the key_input peripheral: bus widths and register word indices.
package key_input_pkg;

    localparam int KEY_DATA_WIDTH = 32;
    localparam int KEY_ADDR_WIDTH = 32;
    localparam int KEY_NUM_WORDS  = 4;

    localparam logic [1:0] KEY_WORD_STATE  = 2'd0;
    localparam logic [1:0] KEY_WORD_RISE   = 2'd1;
    localparam logic [1:0] KEY_WORD_FALL   = 2'd2;
    localparam logic [1:0] KEY_WORD_IRQ_EN = 2'd3;

endpackage

// File: rtl/key_input_if.sv
// Arilla bus: single-cycle request, acknowledge and read data returned one clock later.
interface arilla_bus_if;

    logic                                      req;
    logic                                      we;
    logic [key_input_pkg::KEY_ADDR_WIDTH-1:0]  addr;
    logic [key_input_pkg::KEY_DATA_WIDTH-1:0]  data_ctp;
    logic [key_input_pkg::KEY_DATA_WIDTH-1:0]  data_ptc;
    logic                                      ack;

    modport master (output req, we, addr, data_ctp, input data_ptc, ack);
    modport slave  (input req, we, addr, data_ctp, output data_ptc, ack);

endinterface

// File: rtl/key_input_debounce.sv
// One input bit: two-flop synchroniser, persistence counter and accepted level,
// with single-cycle pulses on the cycle the accepted level changes.
module key_debounce #(
    parameter int DebounceCycles = 500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);

    localparam int                  CntWidth = $clog2(DebounceCycles + 1);
    localparam logic [CntWidth-1:0] Terminal = CntWidth'(DebounceCycles - 1);

    logic                r_meta;
    logic                r_sync;
    logic                r_stable;
    logic [CntWidth-1:0] r_cnt;
    logic                w_accept;

    assign w_accept = (r_sync != r_stable) && (r_cnt == Terminal);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_meta <= i_in;
            r_sync <= r_meta;
            // Any return to the accepted level restarts the persistence count.
            if (r_sync == r_stable) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CntWidth'(1);
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = w_accept && r_sync;
    assign o_fall   = w_accept && !r_sync;

endmodule

// File: rtl/key_input_periph.sv
// Register-window adapter: decodes a SizeWords window at BaseAddress and returns
// read data (sampled in the request cycle) with ack on the following clock.
module periph_mem_interface #(
    parameter int BaseAddress = 0,
    parameter int SizeWords   = 4,
    parameter int DataWidth   = key_input_pkg::KEY_DATA_WIDTH,
    parameter int AddrWidth   = key_input_pkg::KEY_ADDR_WIDTH
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    arilla_bus_if.slave                  bus,
    output logic                         o_wr_en,
    output logic [$clog2(SizeWords)-1:0] o_word,
    output logic [DataWidth-1:0]         o_data_out,
    input  logic [DataWidth-1:0]         i_data_in
);

    localparam int WordBits = $clog2(SizeWords);

    logic [AddrWidth-1:0] w_offset;
    logic                 w_hit;
    logic                 w_unused;
    logic                 r_ack;
    logic [DataWidth-1:0] r_rdata;

    assign w_offset   = bus.addr - AddrWidth'(BaseAddress);
    assign w_hit      = bus.req && (w_offset < AddrWidth'(SizeWords * 4));
    assign o_word     = w_offset[WordBits+1:2];
    assign o_wr_en    = w_hit && bus.we;
    assign o_data_out = bus.data_ctp;
    assign w_unused   = &{1'b0, w_offset[1:0]};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= w_hit;
            r_rdata <= (w_hit && !bus.we) ? i_data_in : '0;
        end
    end

    assign bus.ack      = r_ack;
    assign bus.data_ptc = r_rdata;

endmodule

// File: rtl/key_input.sv
// Debounced key/switch input peripheral with sticky W1C edge flags.
// Define KEY_INPUT_IRQ_EN to build the IRQ_EN register and the registered irq output.
module key_input
    import key_input_pkg::*;
#(
    parameter int BaseAddress    = 0,
    parameter int NumInputs      = 4,
    parameter int DebounceCycles = 500000,
    parameter int ActiveLow      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NumInputs-1:0] keys,
    output logic                 irq,
    arilla_bus_if.slave          bus_interface
);

    localparam int DataWidth = KEY_DATA_WIDTH;
    localparam int WordBits  = $clog2(KEY_NUM_WORDS);

    logic [NumInputs-1:0] w_in;
    logic [NumInputs-1:0] w_stable;
    logic [NumInputs-1:0] w_rise;
    logic [NumInputs-1:0] w_fall;
    logic [NumInputs-1:0] w_clr_rise;
    logic [NumInputs-1:0] w_clr_fall;
    logic [NumInputs-1:0] w_irq_en;
    logic                 w_rst_n;
    logic                 w_wr_en;
    logic [WordBits-1:0]  w_word;
    logic [DataWidth-1:0] w_data_out;
    logic [DataWidth-1:0] w_rdata;
    logic                 w_unused;
    logic [NumInputs-1:0] r_rise;
    logic [NumInputs-1:0] r_fall;

    // Inversion happens before synchronisation so a pressed active-low key reads 1.
    assign w_in     = keys ^ {NumInputs{ActiveLow != 0}};
    assign w_rst_n  = ~rst;
    assign w_unused = &{1'b0, w_data_out};

    for (genvar gi = 0; gi < NumInputs; gi++) begin : g_db
        key_debounce #(.DebounceCycles(DebounceCycles)) u_db (
            .i_clk    (clk),
            .i_rst    (rst),
            .i_in     (w_in[gi]),
            .o_stable (w_stable[gi]),
            .o_rise   (w_rise[gi]),
            .o_fall   (w_fall[gi])
        );
    end

    periph_mem_interface #(
        .BaseAddress (BaseAddress),
        .SizeWords   (KEY_NUM_WORDS),
        .DataWidth   (DataWidth),
        .AddrWidth   (KEY_ADDR_WIDTH)
    ) u_mem (
        .i_clk      (clk),
        .i_rst_n    (w_rst_n),
        .bus        (bus_interface),
        .o_wr_en    (w_wr_en),
        .o_word     (w_word),
        .o_data_out (w_data_out),
        .i_data_in  (w_rdata)
    );

    assign w_clr_rise = (w_wr_en && w_word == KEY_WORD_RISE) ? w_data_out[NumInputs-1:0] : '0;
    assign w_clr_fall = (w_wr_en && w_word == KEY_WORD_FALL) ? w_data_out[NumInputs-1:0] : '0;

    // Set is OR'd in after the clear so a same-cycle edge is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= (r_rise & ~w_clr_rise) | w_rise;
            r_fall <= (r_fall & ~w_clr_fall) | w_fall;
        end
    end

`ifdef KEY_INPUT_IRQ_EN
    logic [NumInputs-1:0] r_irq_en;
    logic                 r_irq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_en <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_en && w_word == KEY_WORD_IRQ_EN) begin
                r_irq_en <= w_data_out[NumInputs-1:0];
            end
            r_irq <= |((r_rise | r_fall) & r_irq_en);
        end
    end

    assign w_irq_en = r_irq_en;
    assign irq      = r_irq;
`else
    assign w_irq_en = '0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        case (w_word)
            KEY_WORD_STATE:  w_rdata[NumInputs-1:0] = w_stable;
            KEY_WORD_RISE:   w_rdata[NumInputs-1:0] = r_rise;
            KEY_WORD_FALL:   w_rdata[NumInputs-1:0] = r_fall;
            KEY_WORD_IRQ_EN: w_rdata[NumInputs-1:0] = w_irq_en;
            default:         w_rdata = '0;
        endcase
    end

endmodule
